// File: rtl/trigger_capture_pkg.sv
// Shared types and defaults for the trigger/capture stage that sits behind
// the I2C ADC controller: capture FSM states, slope encoding, and the default
// sample and address widths.
package trigger_capture_pkg;

  localparam int DW_DEF = 12;
  localparam int AW_DEF = 10;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/trigger_capture_if.sv
// Sample stream and read-back port of the capture stage. The producer/display
// side uses the master modport and the capture block uses the slave modport.
interface trigger_capture_if
  import trigger_capture_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output sample_in,
    output sample_valid,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/trigger_capture_ram.sv
// Simple dual-port sample store: synchronous write on port A and a registered
// read on port B, 2**AW words of DW bits. The read register clears on reset
// so rd_data starts at zero; the array itself is never reset.
module capture_ram #(
  parameter int DW = 12,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Port A: write the incoming sample.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // Port B: registered read, one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd <= '0;
    end else begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// Level/slope trigger and circular capture buffer. PRE samples before the
// trigger and DEPTH-PRE after it (the trigger sample included) are kept, then
// the buffer freezes and is read back oldest-first through the read port.
// Optional feature: define TRIG_AUTO_EN to force a trigger after AUTO_TIMEOUT
// valid samples spent in ARMED; without it auto_trig is tied low.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
`ifdef TRIG_AUTO_EN
  ,
  parameter int AUTO_TIMEOUT = 4095
`endif
) (
  input  logic                clk,
  input  logic                rst,
  trigger_capture_if.slave    bus,
  input  logic                arm,
  input  logic [DW-1:0]       trig_level,
  input  logic                trig_slope,
  input  logic [AW-1:0]       pre_len,
  output logic                busy,
  output logic                done,
  output logic                triggered,
  output logic                auto_trig
);

  cap_state_t    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pre_q;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] start;
  logic [DW-1:0] prev;
  logic          prev_ok;
  logic          wr_en;
  logic          real_hit;
  logic          force_hit;
  logic          trig_fire;
  logic [AW-1:0] rd_phys;
  logic [DW-1:0] rd_q;

  // Unsigned threshold crossing between the previous and current sample.
  function automatic logic edge_hit(input logic          slope,
                                    input logic [DW-1:0] p,
                                    input logic [DW-1:0] c,
                                    input logic [DW-1:0] lvl);
    logic hit;
    hit = 1'b0;
    case (slope)
      SLOPE_RISE: hit = (p < lvl) && (c >= lvl);
      SLOPE_FALL: hit = (p > lvl) && (c <= lvl);
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Write gate: samples land in RAM only while acquiring; a sample that
  // arrives with arm is dropped, and once the post budget is spent (PRE at
  // its maximum) nothing more may overwrite the oldest pre-trigger sample.
  always_comb begin
    wr_en = bus.sample_valid && !arm &&
            ((state == PRETRIG) || (state == ARMED) ||
             ((state == POST) && (post_cnt != '0)));
  end

  // Real trigger: needs a valid previous sample from this acquisition.
  always_comb begin
    real_hit = (state == ARMED) && wr_en && prev_ok &&
               edge_hit(trig_slope, prev, bus.sample_in, trig_level);
  end

`ifdef TRIG_AUTO_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);

  logic [TW-1:0] to_cnt;

  // Timeout fires on the AUTO_TIMEOUT-th valid sample seen in ARMED.
  always_comb begin
    force_hit = (state == ARMED) && wr_en && (to_cnt == TW'(AUTO_TIMEOUT - 1));
  end

  // Timeout counter and the forced-trigger flag; a real edge in the same
  // cycle as the timeout takes precedence and leaves auto_trig low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      auto_trig <= 1'b0;
    end else if (arm) begin
      to_cnt    <= '0;
      auto_trig <= 1'b0;
    end else if ((state == ARMED) && wr_en) begin
      to_cnt <= to_cnt + 1'b1;
      if (trig_fire) begin
        auto_trig <= force_hit && !real_hit;
      end
    end
  end
`else
  assign force_hit = 1'b0;
  assign auto_trig = 1'b0;
`endif

  assign trig_fire = real_hit || force_hit;

  // Capture FSM with registered status outputs; arm overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      triggered <= 1'b0;
      wr_ptr    <= '0;
      pre_q     <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trig_ptr  <= '0;
      start     <= '0;
      prev      <= '0;
      prev_ok   <= 1'b0;
    end else if (arm) begin
      // An AW-bit pre_len can never exceed DEPTH-1, so no clamp is needed.
      pre_q     <= pre_len;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      wr_ptr    <= '0;
      triggered <= 1'b0;
      prev_ok   <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      state     <= (pre_len == '0) ? ARMED : PRETRIG;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + 1'b1;
        prev    <= bus.sample_in;
        prev_ok <= 1'b1;
      end
      case (state)
        PRETRIG: begin
          if (wr_en) begin
            pre_cnt <= pre_cnt + 1'b1;
            if ((pre_cnt + 1'b1) == pre_q) begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (trig_fire) begin
            trig_ptr  <= wr_ptr;
            triggered <= 1'b1;
            // DEPTH-1-PRE in AW bits is the bitwise complement of PRE.
            post_cnt  <= ~pre_q;
            state     <= POST;
          end
        end
        POST: begin
          if (post_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            start <= trig_ptr - pre_q;
          end else if (wr_en) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              start <= trig_ptr - pre_q;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Logical index 0 maps to the oldest sample; the sum wraps naturally.
  assign rd_phys = start + bus.rd_addr;

  capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk (clk),
    .rst (rst),
    .we  (wr_en),
    .wa  (wr_ptr),
    .wd  (bus.sample_in),
    .ra  (rd_phys),
    .rd  (rd_q)
  );

  assign bus.rd_data = rd_q;

endmodule
